// File: rtl/core_inst_pkg.sv
// Shared types and instruction-word layout for the core instruction sequencer.
package core_inst_pkg;

  localparam int CNT_W = 8;
  localparam int AW    = 11;

  localparam int ACC_B      = 33;
  localparam int CEN_P_B    = 32;
  localparam int WEN_P_B    = 31;
  localparam int A_P_LSB    = 20;
  localparam int CEN_X_B    = 19;
  localparam int WEN_X_B    = 18;
  localparam int A_X_LSB    = 7;
  localparam int OFIFO_RD_B = 6;
  localparam int IFIFO_WR_B = 5;
  localparam int IFIFO_RD_B = 4;
  localparam int L0_RD_B    = 3;
  localparam int L0_WR_B    = 2;
  localparam int EXEC_B     = 1;
  localparam int LOAD_B     = 0;

  localparam logic [33:0] INST_IDLE = 34'h1_800C_0000;

  typedef enum logic [3:0] {
    S_IDLE,
    S_W_RD,
    S_W_TAIL,
    S_K_LOAD,
    S_GAP,
    S_A_RD,
    S_A_TAIL,
    S_EXEC,
    S_DRAIN,
    S_NEXT,
    S_DONE
  } state_t;

  // acc and the ififo controls are never used by this sequencer, so they stay 0.
  function automatic logic [33:0] pack_inst(
    input logic          cen_p,
    input logic          wen_p,
    input logic [AW-1:0] a_p,
    input logic          cen_x,
    input logic          wen_x,
    input logic [AW-1:0] a_x,
    input logic          ofifo_rd,
    input logic          l0_rd,
    input logic          l0_wr,
    input logic          exec,
    input logic          load
  );
    logic [33:0] v;
    v                   = '0;
    v[ACC_B]            = 1'b0;
    v[CEN_P_B]          = cen_p;
    v[WEN_P_B]          = wen_p;
    v[A_P_LSB +: AW]    = a_p;
    v[CEN_X_B]          = cen_x;
    v[WEN_X_B]          = wen_x;
    v[A_X_LSB +: AW]    = a_x;
    v[OFIFO_RD_B]       = ofifo_rd;
    v[IFIFO_WR_B]       = 1'b0;
    v[IFIFO_RD_B]       = 1'b0;
    v[L0_RD_B]          = l0_rd;
    v[L0_WR_B]          = l0_wr;
    v[EXEC_B]           = exec;
    v[LOAD_B]           = load;
    return v;
  endfunction

endpackage

// File: rtl/core_inst_seq_counter.sv
// Loadable up-counter with a terminal-count flag (count equals i_last).
module seq_counter
  import core_inst_pkg::*;
#(
  parameter int W = CNT_W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_en,
  input  logic [W-1:0] i_last,
  output logic [W-1:0] o_count,
  output logic         o_tc
);

  logic [W-1:0] r_count;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_en) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_count = r_count;
  assign o_tc    = (r_count == i_last);

endmodule

// File: rtl/core_inst_seq.sv
// Per-kij instruction sequencer: kernel load, activation load, execute and psum drain.
// The instruction word is registered from next-state values, so inst always matches the held state.
module core_inst_seq
  import core_inst_pkg::*;
#(
  parameter int          col      = 8,
  parameter int          row      = 8,
  parameter int          len_nij  = 36,
  parameter int          len_kij  = 9,
  parameter logic [10:0] W_BASE   = 11'h400,
  parameter int          LOAD_CYC = row + col,
  parameter int          GAP_CYC  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        ofifo_valid,
  output logic [33:0] inst,
  output logic        busy,
  output logic        done,
  output logic [3:0]  kij
);

  localparam logic [CNT_W-1:0] COL_LAST  = CNT_W'(col - 1);
  localparam logic [CNT_W-1:0] LOAD_LAST = CNT_W'(LOAD_CYC - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYC - 1);
  localparam logic [CNT_W-1:0] NIJ_LAST  = CNT_W'(len_nij - 1);
  localparam logic [CNT_W-1:0] NIJ_CNT   = CNT_W'(len_nij);
  localparam logic [3:0]       KIJ_LAST  = 4'(len_kij - 1);
  localparam logic [AW-1:0]    COL_A     = AW'(col);
  localparam logic [AW-1:0]    NIJ_A     = AW'(len_nij);

  state_t            r_state, w_state_next;
  logic [33:0]       r_inst, w_inst_next;
  logic              r_busy, r_done;
  logic [3:0]        r_kij, w_kij_next;

  logic [CNT_W-1:0]  w_ph, w_ph_last, w_ph_next, w_d;
  logic              w_ph_tc, w_ph_load, w_ph_en;
  logic              w_d_tc, w_d_load, w_fire, w_wr_pend;

  logic              w_cen_x, w_cen_p, w_l0_wr, w_l0_rd, w_exec, w_load;
  logic [AW-1:0]     w_a_x, w_a_p;

  always_comb begin
    w_ph_last = '0;
    w_ph_en   = 1'b0;
    case (r_state)
      S_W_RD:             begin w_ph_last = COL_LAST;  w_ph_en = 1'b1; end
      S_K_LOAD:           begin w_ph_last = LOAD_LAST; w_ph_en = 1'b1; end
      S_GAP:              begin w_ph_last = GAP_LAST;  w_ph_en = 1'b1; end
      S_A_RD, S_EXEC:     begin w_ph_last = NIJ_LAST;  w_ph_en = 1'b1; end
      S_W_TAIL, S_A_TAIL: begin w_ph_last = '0;        w_ph_en = 1'b1; end
      default:            ;
    endcase
  end

  seq_counter #(.W(CNT_W)) u_phase (
    .clk        (clk),
    .reset      (reset),
    .i_load     (w_ph_load),
    .i_load_val ({CNT_W{1'b0}}),
    .i_en       (w_ph_en),
    .i_last     (w_ph_last),
    .o_count    (w_ph),
    .o_tc       (w_ph_tc)
  );

  always_comb begin
    w_state_next = r_state;
    w_kij_next   = r_kij;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_next = S_W_RD;
          w_kij_next   = '0;
        end
      end
      S_W_RD:   if (w_ph_tc) w_state_next = S_W_TAIL;
      S_W_TAIL: w_state_next = S_K_LOAD;
      S_K_LOAD: if (w_ph_tc) w_state_next = S_GAP;
      S_GAP:    if (w_ph_tc) w_state_next = S_A_RD;
      S_A_RD:   if (w_ph_tc) w_state_next = S_A_TAIL;
      S_A_TAIL: w_state_next = S_EXEC;
      S_EXEC:   if (w_ph_tc) w_state_next = S_DRAIN;
      // Leave only once no read is outstanding, i.e. the last pmem write is in this cycle.
      S_DRAIN:  if (w_d_tc && !r_inst[OFIFO_RD_B]) w_state_next = S_NEXT;
      S_NEXT: begin
        if (r_kij == KIJ_LAST) begin
          w_state_next = S_DONE;
        end else begin
          w_state_next = S_W_RD;
          w_kij_next   = r_kij + 4'd1;
        end
      end
      S_DONE:   w_state_next = S_IDLE;
      default:  w_state_next = S_IDLE;
    endcase
  end

  assign w_ph_load = (w_state_next != r_state);
  assign w_ph_next = w_ph_load ? '0 : (w_ph_en ? w_ph + 1'b1 : w_ph);

  // ofifo_valid is sampled at the edge; the resulting read appears in the following registered word.
  assign w_d_load  = (w_state_next != S_DRAIN);
  assign w_fire    = !w_d_load && ofifo_valid && !w_d_tc;
  assign w_wr_pend = (r_state == S_DRAIN) && r_inst[OFIFO_RD_B];

  seq_counter #(.W(CNT_W)) u_drain (
    .clk        (clk),
    .reset      (reset),
    .i_load     (w_d_load),
    .i_load_val ({CNT_W{1'b0}}),
    .i_en       (w_fire),
    .i_last     (NIJ_CNT),
    .o_count    (w_d),
    .o_tc       (w_d_tc)
  );

  always_comb begin
    w_cen_x = 1'b1;
    w_a_x   = '0;
    w_cen_p = 1'b1;
    w_a_p   = '0;
    w_l0_wr = 1'b0;
    w_l0_rd = 1'b0;
    w_exec  = 1'b0;
    w_load  = 1'b0;
    case (w_state_next)
      S_W_RD: begin
        w_cen_x = 1'b0;
        w_a_x   = W_BASE + AW'(w_kij_next) * COL_A + AW'(w_ph_next);
        w_l0_wr = (w_ph_next != '0);
      end
      S_W_TAIL, S_A_TAIL: w_l0_wr = 1'b1;
      S_K_LOAD: begin
        w_load  = 1'b1;
        w_l0_rd = 1'b1;
      end
      S_A_RD: begin
        w_cen_x = 1'b0;
        w_a_x   = AW'(w_ph_next);
        w_l0_wr = (w_ph_next != '0);
      end
      S_EXEC: begin
        w_exec  = 1'b1;
        w_l0_rd = 1'b1;
      end
      S_DRAIN: begin
        if (w_wr_pend) begin
          w_cen_p = 1'b0;
          w_a_p   = AW'(r_kij) * NIJ_A + AW'(w_d) - 11'd1;
        end
      end
      default: ;
    endcase
    w_inst_next = pack_inst(w_cen_p, w_cen_p, w_a_p, w_cen_x, 1'b1, w_a_x,
                            w_fire, w_l0_rd, w_l0_wr, w_exec, w_load);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_inst  <= INST_IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_kij   <= '0;
    end else begin
      r_state <= w_state_next;
      r_inst  <= w_inst_next;
      r_busy  <= (w_state_next != S_IDLE);
      r_done  <= (w_state_next == S_DONE);
      r_kij   <= w_kij_next;
    end
  end

  assign inst = r_inst;
  assign busy = r_busy;
  assign done = r_done;
  assign kij  = r_kij;

endmodule

// File: tb/tb_core_inst_seq.sv
// Directed bench for core_inst_seq: a full-size instance plus a single-pass (len_kij=1) instance.
module tb_core_inst_seq;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        ofifo_valid = 1'b1;
  logic        valid1 = 1'b1;
  logic [33:0] inst, inst1;
  logic        busy, busy1, done, done1;
  logic [3:0]  kij, kij1;

  int chk_cnt = 0;
  int pass_cnt = 0;

  localparam logic [33:0] IDLE_W = 34'h1_800C_0000;

  always #5 clk = ~clk;

  core_inst_seq dut (
    .clk(clk), .reset(reset), .start(start), .ofifo_valid(ofifo_valid),
    .inst(inst), .busy(busy), .done(done), .kij(kij)
  );

  core_inst_seq #(.len_kij(1)) dut1 (
    .clk(clk), .reset(reset), .start(start), .ofifo_valid(valid1),
    .inst(inst1), .busy(busy1), .done(done1), .kij(kij1)
  );

  task automatic test_reset();
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      start = (i == 4);
      @(negedge clk);
    end
    start = 1'b0;
    chk_cnt++; if (inst !== IDLE_W) $display("FAIL rst_inst: got %h want %h", inst, IDLE_W); else pass_cnt++;
    chk_cnt++; if (busy !== 1'b0) $display("FAIL rst_busy: got %b want 0", busy); else pass_cnt++;
    chk_cnt++; if (done !== 1'b0) $display("FAIL rst_done: got %b want 0", done); else pass_cnt++;
    chk_cnt++; if (kij !== 4'd0) $display("FAIL rst_kij: got %0d want 0", kij); else pass_cnt++;
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk_cnt++; if (busy !== 1'b0 || inst !== IDLE_W) $display("FAIL rst_start_ignored: busy=%b inst=%h want 0 %h", busy, inst, IDLE_W); else pass_cnt++;
  endtask

  task automatic test_single_pass();
    int kaddr_err = 0, load_cnt = 0, load_first = -1, exec_cnt = 0, exec_first = -1;
    int wr_cnt = 0, wr_err = 0, done_cnt = 0, done_idx = -1;
    logic [15:0] l0w_vec = '0;
    logic [3:0]  mk = '0;
    logic [10:0] ma = '0;
    logic        b147 = 1'bx;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 150; i++) begin
      if (i > 0) @(negedge clk);
      if (i < 8 && (inst1[19] !== 1'b0 || inst1[17:7] !== 11'(11'h400 + i))) kaddr_err++;
      if (i < 16) l0w_vec[i] = inst1[2];
      if (inst1[0] === 1'b1) begin if (load_cnt == 0) load_first = i; load_cnt++; end
      if (inst1[1] === 1'b1) begin if (exec_cnt == 0) exec_first = i; exec_cnt++; end
      if (inst1[32] === 1'b0) begin
        if (inst1[31] !== 1'b0 || inst1[30:20] !== 11'(wr_cnt)) wr_err++;
        wr_cnt++;
      end
      if (done1 === 1'b1) begin done_cnt++; done_idx = i; end
      if (i == 146) begin mk = kij; ma = inst[17:7]; end
      if (i == 147) b147 = busy1;
    end
    chk_cnt++; if (kaddr_err !== 0) $display("FAIL sp_kaddr: errors=%0d want 0", kaddr_err); else pass_cnt++;
    chk_cnt++; if (l0w_vec !== 16'h01FE) $display("FAIL sp_l0wr: got %h want 01fe", l0w_vec); else pass_cnt++;
    chk_cnt++; if (load_cnt !== 16) $display("FAIL sp_load_cnt: got %0d want 16", load_cnt); else pass_cnt++;
    chk_cnt++; if (load_first !== 9) $display("FAIL sp_load_first: got %0d want 9", load_first); else pass_cnt++;
    chk_cnt++; if (exec_cnt !== 36) $display("FAIL sp_exec_cnt: got %0d want 36", exec_cnt); else pass_cnt++;
    chk_cnt++; if (exec_first !== 72) $display("FAIL sp_exec_first: got %0d want 72", exec_first); else pass_cnt++;
    chk_cnt++; if (wr_cnt !== 36) $display("FAIL sp_wr_cnt: got %0d want 36", wr_cnt); else pass_cnt++;
    chk_cnt++; if (wr_err !== 0) $display("FAIL sp_wr_addr: errors=%0d want 0", wr_err); else pass_cnt++;
    chk_cnt++; if (done_cnt !== 1) $display("FAIL sp_done_cnt: got %0d want 1", done_cnt); else pass_cnt++;
    chk_cnt++; if (done_idx !== 146) $display("FAIL sp_done_idx: got %0d want 146", done_idx); else pass_cnt++;
    chk_cnt++; if (b147 !== 1'b0) $display("FAIL sp_busy_after: got %b want 0", b147); else pass_cnt++;
    chk_cnt++; if (kij1 !== 4'd0) $display("FAIL sp_kij_final: got %0d want 0", kij1); else pass_cnt++;
    chk_cnt++; if (mk !== 4'd1 || ma !== 11'h408) $display("FAIL sp_pass1_start: kij=%0d addr=%h want 1 408", mk, ma); else pass_cnt++;
  endtask

  task automatic test_full_run();
    int k3_cnt = 0, p3_cnt = 0, done_cnt = 0, done_idx = -1;
    logic [10:0] k3_first = '0, k3_last = '0, p3_first = '0, p3_last = '0, last_p = '0;
    logic done_busy = 1'bx, busy_after = 1'bx;
    logic [3:0] kij_final = 'x;
    for (int i = 150; i < 2000; i++) begin
      @(negedge clk);
      if (kij == 4'd3 && inst[19] === 1'b0 && inst[17:7] >= 11'h400) begin
        if (k3_cnt == 0) k3_first = inst[17:7];
        k3_last = inst[17:7];
        k3_cnt++;
      end
      if (inst[32] === 1'b0) begin
        last_p = inst[30:20];
        if (kij == 4'd3) begin
          if (p3_cnt == 0) p3_first = inst[30:20];
          p3_last = inst[30:20];
          p3_cnt++;
        end
      end
      if (done === 1'b1) begin done_cnt++; done_idx = i; done_busy = busy; end
      if (done_cnt > 0 && i == done_idx + 1) begin
        busy_after = busy;
        kij_final  = kij;
        break;
      end
    end
    chk_cnt++; if (k3_first !== 11'h418) $display("FAIL fr_k3_first: got %h want 418", k3_first); else pass_cnt++;
    chk_cnt++; if (k3_last !== 11'h41F) $display("FAIL fr_k3_last: got %h want 41f", k3_last); else pass_cnt++;
    chk_cnt++; if (k3_cnt !== 8) $display("FAIL fr_k3_cnt: got %0d want 8", k3_cnt); else pass_cnt++;
    chk_cnt++; if (p3_first !== 11'd108) $display("FAIL fr_p3_first: got %0d want 108", p3_first); else pass_cnt++;
    chk_cnt++; if (p3_last !== 11'd143) $display("FAIL fr_p3_last: got %0d want 143", p3_last); else pass_cnt++;
    chk_cnt++; if (p3_cnt !== 36) $display("FAIL fr_p3_cnt: got %0d want 36", p3_cnt); else pass_cnt++;
    chk_cnt++; if (done_cnt !== 1) $display("FAIL fr_done_cnt: got %0d want 1", done_cnt); else pass_cnt++;
    chk_cnt++; if (done_idx !== 1314) $display("FAIL fr_done_idx: got %0d want 1314", done_idx); else pass_cnt++;
    chk_cnt++; if (last_p !== 11'd323) $display("FAIL fr_last_pmem: got %0d want 323", last_p); else pass_cnt++;
    chk_cnt++; if (done_busy !== 1'b1) $display("FAIL fr_busy_at_done: got %b want 1", done_busy); else pass_cnt++;
    chk_cnt++; if (busy_after !== 1'b0) $display("FAIL fr_busy_after: got %b want 0", busy_after); else pass_cnt++;
    chk_cnt++; if (kij_final !== 4'd8) $display("FAIL fr_kij_final: got %0d want 8", kij_final); else pass_cnt++;
  endtask

  task automatic test_start_mid_exec();
    int exec_cnt = 0, busy_drop = 0;
    logic ex80 = 1'bx;
    logic [3:0] k100 = 'x, k146 = 'x;
    logic [10:0] a146 = 'x;
    ofifo_valid = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (i > 0) @(negedge clk);
      start = 1'b0;
      if (i < 146 && inst[1] === 1'b1) exec_cnt++;
      if (i < 146 && busy !== 1'b1) busy_drop++;
      if (i == 80) begin ex80 = inst[1]; start = 1'b1; end
      if (i == 100) k100 = kij;
      if (i == 146) begin k146 = kij; a146 = inst[17:7]; end
    end
    start = 1'b0;
    chk_cnt++; if (ex80 !== 1'b1) $display("FAIL me_in_exec: got %b want 1", ex80); else pass_cnt++;
    chk_cnt++; if (exec_cnt !== 36) $display("FAIL me_exec_cnt: got %0d want 36", exec_cnt); else pass_cnt++;
    chk_cnt++; if (busy_drop !== 0) $display("FAIL me_busy: drops=%0d want 0", busy_drop); else pass_cnt++;
    chk_cnt++; if (k100 !== 4'd0) $display("FAIL me_kij: got %0d want 0", k100); else pass_cnt++;
    chk_cnt++; if (k146 !== 4'd1 || a146 !== 11'h408) $display("FAIL me_next_pass: kij=%0d addr=%h want 1 408", k146, a146); else pass_cnt++;
  endtask

  task automatic test_drain_stall();
    bit pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    int rd_cnt = 0, bad_rd = 0, wr_cnt = 0, wr_err = 0;
    bit reached = 1'b0;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      if (kij == 4'd2) begin reached = 1'b1; break; end
      if (inst[6] === 1'b1) begin
        rd_cnt++;
        if (ofifo_valid !== 1'b1) bad_rd++;
      end
      if (inst[32] === 1'b0) begin
        if (inst[31] !== 1'b0 || inst[30:20] !== 11'(36 + wr_cnt)) wr_err++;
        wr_cnt++;
      end
      ofifo_valid = pat[i % 4];
    end
    ofifo_valid = 1'b1;
    chk_cnt++; if (reached !== 1'b1) $display("FAIL ds_timeout: pass did not finish in 600 cycles"); else pass_cnt++;
    chk_cnt++; if (bad_rd !== 0) $display("FAIL ds_rd_without_valid: got %0d want 0", bad_rd); else pass_cnt++;
    chk_cnt++; if (rd_cnt !== 36) $display("FAIL ds_rd_cnt: got %0d want 36", rd_cnt); else pass_cnt++;
    chk_cnt++; if (wr_cnt !== 36) $display("FAIL ds_wr_cnt: got %0d want 36", wr_cnt); else pass_cnt++;
    chk_cnt++; if (wr_err !== 0) $display("FAIL ds_wr_addr: errors=%0d want 0", wr_err); else pass_cnt++;
  endtask

  task automatic test_reset_mid_drain();
    int rd_seen = 0;
    bit reached = 1'b0;
    ofifo_valid = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (kij == 4'd4 && inst[6] === 1'b1) begin
        rd_seen++;
        if (rd_seen == 5) begin reached = 1'b1; break; end
      end
    end
    chk_cnt++; if (reached !== 1'b1) $display("FAIL rd_timeout: kij=4 drain not reached"); else pass_cnt++;
    reset = 1'b0;
    @(negedge clk);
    chk_cnt++; if (inst !== IDLE_W) $display("FAIL rd_inst: got %h want %h", inst, IDLE_W); else pass_cnt++;
    chk_cnt++; if (busy !== 1'b0) $display("FAIL rd_busy: got %b want 0", busy); else pass_cnt++;
    chk_cnt++; if (kij !== 4'd0) $display("FAIL rd_kij: got %0d want 0", kij); else pass_cnt++;
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk_cnt++; if (busy !== 1'b0 || inst !== IDLE_W) $display("FAIL rd_stay_idle: busy=%b inst=%h", busy, inst); else pass_cnt++;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk_cnt++; if (inst[19] !== 1'b0 || inst[17:7] !== 11'h400) $display("FAIL rd_restart_addr: cen=%b addr=%h want 0 400", inst[19], inst[17:7]); else pass_cnt++;
    chk_cnt++; if (kij !== 4'd0 || busy !== 1'b1) $display("FAIL rd_restart_state: kij=%0d busy=%b want 0 1", kij, busy); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_single_pass();
    test_full_run();
    test_start_mid_exec();
    test_drain_stall();
    test_reset_mid_drain();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/core_inst_seq.md
Name: core_inst_seq

Overview:
- Instruction sequencer upstream of `core`. It generates the 34-bit `inst` word cycle by cycle, replacing the hand-written sequencing of the kij loop.
- For each kij it runs, in order:
  - kernel SRAM→L0, then L0→PE load, then a settle gap;
  - activation SRAM→L0, then execute;
  - OFIFO drain into pmem, at pmem address kij*len_nij+n.
- Raises `done` after `len_kij` passes. Accumulation/SFP sequencing is out of scope.

Parameters:
- `col`, 8, PE columns; also the number of kernel words per kij.
- `row`, 8, PE rows.
- `len_nij`, 36, activation words per pass; also the psum words drained per pass.
- `len_kij`, 9, kernel positions (passes).
- `W_BASE`, 11'h400, xmem base address of kernel words.
- `LOAD_CYC`, 16, cycles with load/l0_rd asserted (row+col).
- `GAP_CYC`, 10, idle cycles after the kernel load.

Ports:
- `clk`  in  1  clock; all logic on the rising edge.
- `reset`  in  1  synchronous, active-low reset.
- `start`  in  1  one-cycle request; sampled only in IDLE.
- `ofifo_valid`  in  1  from `core`; OFIFO holds a full row.
- `inst`  out  34  registered instruction word to `core.inst`.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse after the final pass.
- `kij`  out  4  index of the current pass.

Behaviour:
- inst bit map:
  - [33] acc; [32] CEN_pmem; [31] WEN_pmem; [30:20] A_pmem;
  - [19] CEN_xmem; [18] WEN_xmem; [17:7] A_xmem;
  - [6] ofifo_rd; [5] ififo_wr; [4] ififo_rd; [3] l0_rd; [2] l0_wr; [1] execute; [0] load.
- IDLE word: CEN/WEN bits = 1, all other bits = 0, i.e. 34'h1_800C_0000. acc, ififo_wr and ififo_rd are always 0.
- Reset (`reset`=0 at posedge): next state IDLE; `inst`=IDLE word; `busy`=0; `done`=0; `kij`=0; all counters 0. This applies in any state, including mid-pass.
- All outputs are registered. `inst` in cycle c reflects the state/counter held in cycle c.
- SRAM read latency is 1 cycle. Therefore:
  - `l0_wr` is asserted one cycle after each xmem read;
  - a pmem write is issued one cycle after each `ofifo_rd`.
- States and transitions:
  - IDLE: on `start`=1 go to W_RD with `kij`=0; otherwise stay.
  - W_RD, t=0..col-1: CEN_xmem=0, WEN_xmem=1, A_xmem=W_BASE+kij*col+t; l0_wr=1 for t≥1. Go to W_TAIL.
  - W_TAIL, 1 cycle: l0_wr=1, xmem idle. Go to K_LOAD.
  - K_LOAD, LOAD_CYC cycles: load=1, l0_rd=1. Go to GAP.
  - GAP, GAP_CYC cycles: IDLE word. Go to A_RD.
  - A_RD, n=0..len_nij-1: CEN_xmem=0, WEN_xmem=1, A_xmem=n; l0_wr=1 for n≥1. Go to A_TAIL.
  - A_TAIL, 1 cycle: l0_wr=1. Go to EXEC.
  - EXEC, len_nij cycles: execute=1, l0_rd=1. Go to DRAIN.
  - DRAIN:
    - Counter d counts up to len_nij.
    - `ofifo_rd`=1 in a cycle iff `ofifo_valid`=1 and d<len_nij; d increments when it fires.
    - In the cycle after each `ofifo_rd`: CEN_pmem=0, WEN_pmem=0, A_pmem=kij*len_nij+(d-1).
    - `ofifo_valid`=0 stalls the drain indefinitely; no timeout.
    - Exit when d==len_nij and the last pmem write has been issued. Go to NEXT.
  - NEXT, 1 cycle: IDLE word. If kij==len_kij-1 go to DONE; else increment kij and go to W_RD.
  - DONE, 1 cycle: `done`=1, `busy`=1. Go to IDLE; `kij` holds its final value until the next `start`.
- `start` while busy is ignored.
- Address arithmetic is 11-bit and wraps modulo 2048; with defaults no wrap occurs (max pmem address 323).
- Stall-free cycles per pass = (col+1)+LOAD_CYC+GAP_CYC+(len_nij+1)+len_nij+(len_nij+1)+1 = 146 with defaults.

Decomposition:
- Package `core_inst_pkg`:
  - state enum;
  - inst bit-position constants (ACC_B=33 … LOAD_B=0);
  - INST_IDLE = 34'h1_800C_0000;
  - a function packing fields into the 34-bit word.
- One sub-module, `seq_counter`: a loadable up-counter with terminal-count flag, instantiated for the phase counter and the drain counter.

Test Plan:
- Reset check: hold `reset`=0 for 10 cycles → `inst`=34'h1_800C_0000, `busy`=0, `done`=0, `kij`=0. Pulse `start` during reset → ignored.
- Single pass, `len_kij`=1, `ofifo_valid`=1 throughout:
  - pulse `start` → A_xmem reads 0x400..0x407, then `l0_wr` on exactly 8 consecutive cycles;
  - load high 16 cycles;
  - execute high 36 cycles;
  - 36 pmem writes at addresses 0..35;
  - `done` pulses exactly 146 cycles after the first W_RD cycle.
- Full run, defaults:
  - kij=3 pass reads xmem 0x418..0x41F and writes pmem 108..143;
  - `done` asserts once, after kij=8 (last pmem address 323);
  - `busy` falls the cycle after `done`.
- Drain stall: toggle `ofifo_valid` 1,0,0,1… during DRAIN → `ofifo_rd` only in valid cycles; pmem addresses stay contiguous with no gaps or duplicates; exactly 36 writes.
- `start` pulsed mid-pass (in EXEC) → no effect on state, counters or `kij`.
- `reset`=0 asserted mid-DRAIN at kij=4 → next cycle IDLE word, `busy`=0, `kij`=0; a new `start` restarts from kij=0 at address 0x400.
